// File: rtl/instr_mem_fetch.sv
// Clocked instruction memory with a valid/ready fetch port, RD_LAT-cycle read latency,
// alignment/range fault reporting and an independent program-load write port.
module instr_mem_fetch #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 64,
  parameter int    DEPTH     = 64,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqAddr,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspFault,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData
);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Word-aligned and inside the array; the index compare uses the full address width.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[ADDR_W-1:2]} < ADDR_W'(DEPTH));
  endfunction

  mem_t mem = '{default: '0};

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fault_q, fault_d;

  logic              accept;
  logic              enter_resp;
  logic              ld_we;
  logic [ADDR_W-1:0] rd_addr;

  assign ReqReady = !Reset && ((state_q == IDLE) || ((state_q == RESP) && RspReady));
  assign accept   = ReqValid && ReqReady;
  assign rd_addr  = (state_q == WAIT) ? addr_q : ReqAddr;
  assign ld_we    = LdEn && !Reset && addr_ok(LdAddr);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    fault_d    = fault_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if ((state_q == RESP) && RspReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
        if (accept) begin
          addr_d = ReqAddr;
          cnt_d  = LAT_LOAD;
          if (RD_LAT > 1) state_d = WAIT;
          else            enter_resp = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) enter_resp = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The array is sampled only on the edge that enters RESP; the value then holds.
    if (enter_resp) begin
      state_d = RESP;
      valid_d = 1'b1;
      fault_d = !addr_ok(rd_addr);
      data_d  = fault_d ? '0 : mem[rd_addr[IDX_W+1:2]];
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: the array has no reset so a loaded program survives Reset; a same-edge
  // fetch read sees the old word because the write lands after the edge.
  always_ff @(posedge CLK) begin
    if (ld_we) mem[LdAddr[IDX_W+1:2]] <= LdData;
  end

  assign RspValid = valid_q;
  assign RspData  = data_q;
  assign RspFault = fault_q;

endmodule
